rib_arbiter: RTL and testbench

- Sequential arbiter sharing one RIB slave port among four bus masters:
  - m0 = core ex port
  - m1 = core pc port
  - m2 = jtag
  - m3 = uart debug
- Registers the winning request and holds the grant until the slave acknowledges or a timeout fires.
- Drives hold_flag_o into ctrl, so the core stalls while its ex-port access is pending.

---
 rtl/rib_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_rib_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rib_arbiter.sv
// Four-master RIB arbiter: registers one winning request, holds the grant until the
// slave acks or the wait times out. Optional RIB_ARB_RR_EN selects round-robin arbitration.
module rib_arbiter #(
  parameter int NUM_M   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_M-1:0]      m_req_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [32*NUM_M-1:0]   m_addr_i,
  input  logic [32*NUM_M-1:0]   m_wdata_i,
  output logic [31:0]           m_rdata_o,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic                  s_req_o,
  output logic                  s_we_o,
  output logic [31:0]           s_addr_o,
  output logic [31:0]           s_wdata_o,
  input  logic [31:0]           s_rdata_i,
  input  logic                  s_ack_i,
  output logic                  hold_flag_o,
  output logic                  err_o
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [NUM_M-1:0]   ack_q, ack_d;
  logic               s_req_q, s_req_d;
  logic [CW-1:0]      cnt_q, cnt_d;
`ifdef RIB_ARB_RR_EN
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      cand;
`endif

  logic [31:0]        m_addr_a  [NUM_M];
  logic [31:0]        m_wdata_a [NUM_M];
  logic [NUM_M-1:0]   grant_oh;
  logic [IW-1:0]      win_idx;
  logic               timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_unpack
      assign m_addr_a[gi]  = m_addr_i[32*gi +: 32];
      assign m_wdata_a[gi] = m_wdata_i[32*gi +: 32];
      assign grant_oh[gi]  = (grant_q == IW'(gi));
    end
  endgenerate

  // Winner selection; only consulted in IDLE.
  always_comb begin
    win_idx = '0;
`ifdef RIB_ARB_RR_EN
    cand = '0;
    // Walk the circle backwards so the candidate nearest ptr+1 is written last.
    for (int k = NUM_M - 1; k >= 0; k--) begin
      cand = ptr_q + IW'(k + 1);
      if (m_req_i[cand]) win_idx = cand;
    end
`else
    for (int k = 0; k < NUM_M; k++) begin
      if (m_req_i[k]) win_idx = IW'(k);
    end
`endif
  end

  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (cnt_q == TMAX);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ack_d   = ack_q;
    s_req_d = s_req_q;
    cnt_d   = cnt_q;
`ifdef RIB_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|m_req_i) begin
          grant_d = win_idx;
          we_d    = m_we_i[win_idx];
          addr_d  = m_addr_a[win_idx];
          wdata_d = m_wdata_a[win_idx];
          cnt_d   = '0;
          s_req_d = 1'b1;
          state_d = WAIT;
`ifdef RIB_ARB_RR_EN
          ptr_d   = win_idx;
`endif
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A slave ack in the expiry cycle takes precedence over the timeout.
        if (s_ack_i) begin
          rdata_d = we_q ? 32'h0 : s_rdata_i;
          err_d   = 1'b0;
          ack_d   = grant_oh;
          s_req_d = 1'b0;
          state_d = DONE;
        end else if (timeout_hit) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          ack_d   = grant_oh;
          s_req_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        ack_d   = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        ack_d   = '0;
        err_d   = 1'b0;
        s_req_d = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      s_req_q <= 1'b0;
      cnt_q   <= '0;
`ifdef RIB_ARB_RR_EN
      ptr_q   <= IW'(NUM_M - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      s_req_q <= s_req_d;
      cnt_q   <= cnt_d;
`ifdef RIB_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign s_req_o     = s_req_q;
  assign s_we_o      = we_q;
  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign m_rdata_o   = rdata_q;
  assign m_ack_o     = ack_q;
  assign err_o       = err_q;
  assign hold_flag_o = m_req_i[0] & ~ack_q[0];

endmodule

// File: tb/tb_rib_arbiter.sv
// Bench for rib_arbiter (TIMEOUT=8): transaction table with scoreboard plus a reset-mid-WAIT
// sequence; expected grants follow RIB_ARB_RR_EN when defined.
module tb_rib_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_req_i, m_we_i;
  logic [127:0] m_addr_i, m_wdata_i;
  logic [31:0]  m_rdata_o;
  logic [3:0]   m_ack_o;
  logic         s_req_o, s_we_o;
  logic [31:0]  s_addr_o, s_wdata_o, s_rdata_i;
  logic         s_ack_i, hold_flag_o, err_o;

  always #5 clk = ~clk;

  rib_arbiter #(.NUM_M(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i),
    .hold_flag_o(hold_flag_o), .err_o(err_o)
  );

  typedef struct {
    logic [3:0]  raise;
    logic [3:0]  we;
    int          delay;   // WAIT cycle index of slave ack; -1 = never ack
    logic [31:0] sdata;
    logic [31:0] abase;
    logic [31:0] wbase;
    int          g_fix;
    int          g_rr;
  } vec_t;

  typedef struct {
    logic [3:0]  ack;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  vec_t rv;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] active_req;
  bit   prev_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input vec_t v, input int i);
    return v.abase + 32'(i) * 32'h0100_0000;
  endfunction

  function automatic logic [31:0] wdata_of(input vec_t v, input int i);
    return v.wbase + 32'(i) * 32'h0000_1111;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int g, n, w;
    bit ok_stable, ok_hold;
    exp_t e, got;
    logic [31:0] ea, ew;
`ifdef RIB_ARB_RR_EN
    g = v.g_rr;
`else
    g = v.g_fix;
`endif
    active_req = active_req | v.raise;
    m_we_i = v.we;
    for (int i = 0; i < 4; i++) begin
      m_addr_i[32*i +: 32]  = addr_of(v, i);
      m_wdata_i[32*i +: 32] = wdata_of(v, i);
    end
    m_req_i = active_req;
    ea = addr_of(v, g);
    ew = wdata_of(v, g);
    e.ack   = 4'b0001 << g;
    e.err   = (v.delay < 0);
    e.rdata = (e.err || v.we[g]) ? 32'h0 : v.sdata;
    e.waits = e.err ? 7 : v.delay;
    sb.push_back(e);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_req_o && n < 10);
    chk({tag, " s_req latency"}, n, prev_done ? 2 : 1);
    if (!s_req_o) begin
      void'(sb.pop_front());
      active_req[g] = 1'b0;
      m_req_i = active_req;
      prev_done = 1'b0;
      return;
    end

    ok_stable = 1'b1;
    ok_hold   = 1'b1;
    for (w = 0; w < 20; w++) begin
      if (s_addr_o !== ea || s_we_o !== v.we[g] || s_wdata_o !== ew ||
          s_req_o !== 1'b1 || m_ack_o !== 4'b0 || err_o !== 1'b0) ok_stable = 1'b0;
      if (hold_flag_o !== active_req[0]) ok_hold = 1'b0;
      if (w == v.delay) begin
        s_ack_i = 1'b1;
        s_rdata_i = v.sdata;
      end else begin
        s_ack_i = 1'b0;
        s_rdata_i = ~v.sdata;
      end
      @(negedge clk);
      s_ack_i = 1'b0;
      if (m_ack_o != 4'b0) break;
    end

    got = sb.pop_front();
    chk({tag, " slave side stable"}, ok_stable, 1);
    chk({tag, " hold in wait"}, ok_hold, 1);
    chk({tag, " m_ack_o"}, m_ack_o, got.ack);
    chk({tag, " m_rdata_o"}, m_rdata_o, got.rdata);
    chk({tag, " err_o"}, err_o, got.err);
    chk({tag, " wait cycles"}, w, got.waits);
    chk({tag, " s_req_o done"}, s_req_o, 0);
    chk({tag, " hold in done"}, hold_flag_o, active_req[0] & (g != 0));
    $display("txn %s: grant m%0d ack=%b rdata=%h err=%b waits=%0d", tag, g, m_ack_o, m_rdata_o, err_o, w);
    active_req[g] = 1'b0;
    m_req_i = active_req;
    prev_done = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0;
    s_rdata_i = '0; s_ack_i = 1'b0;
    active_req = '0;
    prev_done = 1'b0;

    //            raise    we       dly sdata         abase         wbase         fix rr
    vecs[0]  = '{4'b0001, 4'b0000,  0, 32'hDEAD_BEEF, 32'h1000_0004, 32'h0000_0000, 0, 0};
    vecs[1]  = '{4'b1011, 4'b1011,  0, 32'h1234_5678, 32'h2000_0000, 32'hA000_0000, 3, 1};
    vecs[2]  = '{4'b0000, 4'b1011,  1, 32'h0BAD_F00D, 32'h2000_0040, 32'hB000_0000, 1, 3};
    vecs[3]  = '{4'b0000, 4'b1011,  2, 32'h0F0F_0F0F, 32'h2000_0080, 32'hC000_0000, 0, 0};
    vecs[4]  = '{4'b0100, 4'b0000, -1, 32'h7777_7777, 32'h3000_0000, 32'h0000_0000, 2, 2};
    vecs[5]  = '{4'b0100, 4'b0000,  7, 32'h5A5A_5A5A, 32'h3000_0010, 32'h0000_0000, 2, 2};
    vecs[6]  = '{4'b0001, 4'b0001,  3, 32'h1357_9BDF, 32'h4000_0000, 32'hD000_0000, 0, 0};
    vecs[7]  = '{4'b1111, 4'b0000,  0, 32'hC0DE_0001, 32'h5000_0000, 32'h0000_0000, 3, 1};
    vecs[8]  = '{4'b1111, 4'b0000,  0, 32'hC0DE_0002, 32'h5000_0004, 32'h0000_0000, 3, 2};
    vecs[9]  = '{4'b1111, 4'b0000,  0, 32'hC0DE_0003, 32'h5000_0008, 32'h0000_0000, 3, 3};
    vecs[10] = '{4'b1111, 4'b0000,  0, 32'hC0DE_0004, 32'h5000_000C, 32'h0000_0000, 3, 0};
    vecs[11] = '{4'b1111, 4'b0000,  0, 32'hC0DE_0005, 32'h5000_0010, 32'h0000_0000, 3, 1};
    rv       = '{4'b0010, 4'b0000,  0, 32'h600D_CAFE, 32'h6000_0000, 32'h0000_0000, 1, 1};

    repeat (3) @(negedge clk);
    chk("reset s_req_o", s_req_o, 0);
    chk("reset s_we_o", s_we_o, 0);
    chk("reset s_addr_o", s_addr_o, 0);
    chk("reset s_wdata_o", s_wdata_o, 0);
    chk("reset m_ack_o", m_ack_o, 0);
    chk("reset m_rdata_o", m_rdata_o, 0);
    chk("reset err_o", err_o, 0);
    chk("reset hold_flag_o", hold_flag_o, 0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Remaining requesters restart a transaction; reset it while it waits.
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset s_req_o", s_req_o, 1);
    rst = 1'b0;
    #1;
    chk("async reset s_req_o", s_req_o, 0);
    chk("async reset m_ack_o", m_ack_o, 0);
    chk("async reset err_o", err_o, 0);
    chk("async reset m_rdata_o", m_rdata_o, 0);
    active_req = 4'b0010;
    m_req_i = active_req;
    @(negedge clk);
    chk("held reset m_ack_o", m_ack_o, 0);
    chk("held reset s_req_o", s_req_o, 0);
    rst = 1'b1;
    prev_done = 1'b0;
    run_vec(rv, "rst_recover");

    repeat (3) @(negedge clk);
    chk("idle s_req_o", s_req_o, 0);
    chk("idle m_ack_o", m_ack_o, 0);
    chk("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
